// File: rtl/anchor_pair_issuer_pkg.sv
// Shared defaults and FSM state encoding for the anchor pair issuer.
// Imported by the interface, the lookback ring and the top level.
package anchor_pair_issuer_pkg;

    localparam int DEF_DW       = 32;
    localparam int DEF_DEPTH    = 64;
    localparam int DEF_MAX_DIST = 5000;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/anchor_pair_issuer_if.sv
// Anchor input stream plus scorer pair output of the anchor pair issuer.
// The master drives anchors and pair_ready; the slave (the issuer) drives the rest.
interface anchor_pair_issuer_if
    import anchor_pair_issuer_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x;
    logic [DW-1:0] in_y;
    logic          in_last;

    logic          pair_valid;
    logic          pair_ready;
    logic [DW-1:0] ri_x;
    logic [DW-1:0] ri_y;
    logic [DW-1:0] qi_x;
    logic [DW-1:0] qi_y;
    logic [AW-1:0] pair_ofs;
    logic          anchor_done;

    modport master (
        output in_valid, in_x, in_y, in_last, pair_ready,
        input  in_ready, pair_valid, ri_x, ri_y, qi_x, qi_y, pair_ofs, anchor_done
    );

    modport slave (
        input  in_valid, in_x, in_y, in_last, pair_ready,
        output in_ready, pair_valid, ri_x, ri_y, qi_x, qi_y, pair_ofs, anchor_done
    );

endinterface

// File: rtl/anchor_pair_issuer_ring.sv
// Lookback ring holding {x, y} of recent anchors: one write port and one
// combinational read port.
module anchor_ring
    import anchor_pair_issuer_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [2*DW-1:0]          i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [2*DW-1:0]          o_rdata
);

    logic [2*DW-1:0] r_mem [DEPTH];

    // NOTE: storage is deliberately left without reset; slots are only read
    // once written within the current read, so stale contents never matter.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/anchor_pair_issuer.sv
// Issues (predecessor, current) anchor pairs to a scorer, walking back through
// the lookback ring in increasing offset order until a candidate fails.
module anchor_pair_issuer
    import anchor_pair_issuer_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int MAX_DIST = DEF_MAX_DIST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    anchor_pair_issuer_if.slave      bus
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LIM_MAX  = AW'(DEPTH - 1);
    localparam logic [DW-1:0] DIST_MAX = DW'(MAX_DIST);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_live;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_cur_ptr;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_lim;
    logic [AW-1:0] r_ofs;
    logic [DW-1:0] r_qi_x;
    logic [DW-1:0] r_qi_y;
    logic [DW-1:0] r_ri_x;
    logic [DW-1:0] r_ri_y;
    logic          r_done;

    logic          w_accept;
    logic          w_handshake;
    logic [AW:0]   w_cand_ofs;
    logic [AW-1:0] w_cand_lim;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_q_x;
    logic [DW-1:0] w_cand_x;
    logic [DW-1:0] w_cand_y;
    logic [DW-1:0] w_dist;
    logic [2*DW-1:0] w_rd_data;
    logic          w_issuable;

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_handshake = (r_state == ISSUE) && bus.pair_ready;

    anchor_ring #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata ({bus.in_x, bus.in_y}),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // In IDLE the candidate is ofs=1 relative to the slot being written now;
    // in ISSUE it is the next offset behind the latched current anchor.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave a latch behind.
        w_cand_ofs = '0;
        w_cand_lim = '0;
        w_base     = '0;
        w_q_x      = '0;
        if (r_state == IDLE) begin
            w_cand_ofs = (AW+1)'(1);
            w_cand_lim = r_cnt;
            w_base     = r_wr_ptr;
            w_q_x      = bus.in_x;
        end else begin
            w_cand_ofs = {1'b0, r_ofs} + (AW+1)'(1);
            w_cand_lim = r_lim;
            w_base     = r_cur_ptr;
            w_q_x      = r_qi_x;
        end
    end

    assign w_rd_addr            = w_base - w_cand_ofs[AW-1:0];
    assign {w_cand_x, w_cand_y} = w_rd_data;
    assign w_dist               = (w_q_x > w_cand_x) ? (w_q_x - w_cand_x) : '0;
    assign w_issuable           = (w_cand_ofs <= {1'b0, w_cand_lim}) && (w_dist <= DIST_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_accept && w_issuable)     w_state_nxt = ISSUE;
            ISSUE: if (w_handshake && !w_issuable) w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready    = r_live && (r_state == IDLE);
        bus.pair_valid  = (r_state == ISSUE);
        bus.ri_x        = r_ri_x;
        bus.ri_y        = r_ri_y;
        bus.qi_x        = r_qi_x;
        bus.qi_y        = r_qi_y;
        bus.pair_ofs    = r_ofs;
        bus.anchor_done = r_done;
    end

    // cnt is updated at accept time: the anchor's own limit is captured in
    // r_lim, so the next anchor already sees the post-anchor count.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_wr_ptr  <= '0;
            r_cur_ptr <= '0;
            r_cnt     <= '0;
            r_lim     <= '0;
            r_ofs     <= '0;
            r_qi_x    <= '0;
            r_qi_y    <= '0;
            r_ri_x    <= '0;
            r_ri_y    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;
            if (w_accept) begin
                r_qi_x    <= bus.in_x;
                r_qi_y    <= bus.in_y;
                r_cur_ptr <= r_wr_ptr;
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_lim     <= r_cnt;
                r_cnt     <= bus.in_last ? '0 : ((r_cnt == LIM_MAX) ? r_cnt : r_cnt + AW'(1));
                r_done    <= !w_issuable;
                if (w_issuable) begin
                    r_ri_x <= w_cand_x;
                    r_ri_y <= w_cand_y;
                    r_ofs  <= AW'(1);
                end
            end else if (w_handshake) begin
                r_done <= !w_issuable;
                if (w_issuable) begin
                    r_ri_x <= w_cand_x;
                    r_ri_y <= w_cand_y;
                    r_ofs  <= w_cand_ofs[AW-1:0];
                end
            end
        end
    end

endmodule

// File: doc/anchor_pair_issuer.md
ANCHOR_PAIR_ISSUER -- requirements
Module: anchor_pair_issuer

Interface
REQ-001 The parameter DW SHALL default to 32 and set the coordinate width.
REQ-002 The parameter DEPTH SHALL default to 64 (power of two, ≥4) and set the lookback ring size.
REQ-003 The parameter MAX_DIST SHALL default to 5000 and set the x-distance early-stop bound.
REQ-004 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 The port rst_n SHALL be an input, 1 bit wide, carrying an asynchronous, active-low reset.
REQ-006 The ports in_valid, in_ready, in_x[DW-1:0], in_y[DW-1:0] and in_last SHALL form the anchor input stream; in_ready is an output, the rest are inputs, and in_last marks the final anchor of a read.
REQ-007 The ports pair_valid (out), pair_ready (in), ri_x, ri_y, qi_x, qi_y (out, DW each) SHALL form the scorer pair output: ri is the predecessor and qi is the current anchor.
REQ-008 The port pair_ofs[$clog2(DEPTH)-1:0] SHALL be an output giving the predecessor distance (1 = immediately preceding anchor).
REQ-009 The port anchor_done SHALL be an output, 1 bit wide, pulsing for one cycle when issuing for an anchor ends.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (in_ready=1, pair_valid=0) and ISSUE (in_ready=0, pair_valid=1).
REQ-011 On in_valid&&in_ready, the anchor SHALL be written to ring[wr_ptr], latched as qi_x/qi_y, and wr_ptr SHALL increment modulo DEPTH.
REQ-012 The predecessor limit SHALL be lim = min(cnt, DEPTH-1), where cnt is the number of prior anchors in the current read (saturating at DEPTH-1).
REQ-013 The block SHALL evaluate a candidate at ofs as ring[(cur_ptr-ofs) mod DEPTH], where cur_ptr is the slot of the current anchor.
REQ-014 A candidate SHALL be issued only if ofs ≤ lim and (qi_x - r_x) ≤ MAX_DIST; when r_x > qi_x the distance SHALL be taken as 0.
REQ-015 On accept, the block SHALL evaluate the candidate at ofs=1: if issuable, it SHALL enter ISSUE at the next cycle with registered ri/pair_ofs; otherwise it SHALL remain in IDLE and pulse anchor_done in the next cycle.
REQ-016 In ISSUE, outputs SHALL hold stable while pair_ready=0.
REQ-017 On a pair handshake in ISSUE, the block SHALL evaluate ofs+1: if issuable, it SHALL load that pair the next cycle, giving a throughput of 1 pair/cycle; otherwise it SHALL enter IDLE and pulse anchor_done in the next cycle.
REQ-018 Pairs SHALL be issued in strictly increasing ofs order, and the first failing candidate SHALL terminate the anchor (no skipping).
REQ-019 After anchor_done for an anchor accepted with in_last=1, cnt SHALL be cleared to 0; otherwise cnt SHALL increment (saturating).
REQ-020 Input acceptance latency SHALL be 1 cycle to the first pair_valid; the next anchor SHALL be acceptable in the cycle anchor_done is high.
REQ-021 Pointer wrap-around SHALL be invisible: ofs arithmetic is modulo DEPTH, and lim ≤ DEPTH-1 guarantees the current slot is never re-read.

Reset
REQ-022 Assertion of rst_n SHALL asynchronously force IDLE with wr_ptr=0, cnt=0, pair_valid=0, anchor_done=0, in_ready=0 during reset and 1 in the first cycle after release, and all data outputs=0.
REQ-023 A reset mid-ISSUE SHALL drop the in-flight anchor with no anchor_done; ring contents need not be cleared.

Structure
REQ-024 A shared package SHALL hold DW, DEPTH, MAX_DIST defaults and the state enum {IDLE, ISSUE}.
REQ-025 The ring storage SHALL be a sub-module anchor_ring: DEPTH×2·DW registers, one write port and one combinational read port, with no reset on storage.

Verification
REQ-026 Verification SHALL cover a first anchor of a read (x=100, y=100): no pair is issued and anchor_done fires 1 cycle after accept; the second anchor (150, 160) yields one pair, ri=(100,100), qi=(150,160), ofs=1.
REQ-027 Verification SHALL cover 70 anchors with x=10·k and pair_ready=1: anchor 70 issues exactly 63 pairs with ofs 1..63 on consecutive cycles.
REQ-028 Verification SHALL cover early stop with anchors x=0, 1000, 7000, 7100: anchor 7100 issues ofs=1 (x=7000) and stops before x=1000 (distance 6100 > 5000).
REQ-029 Verification SHALL cover backpressure: pair_ready toggling 1010… must leave outputs unchanged across stall cycles, with no pair lost or duplicated against the reference model.
REQ-030 Verification SHALL cover an in_last anchor followed by a new anchor: the new anchor issues zero pairs.
REQ-031 Verification SHALL cover rst_n asserted during ISSUE: pair_valid falls immediately, and after release the first accepted anchor issues no pairs.
